// File: rtl/regfile_cmd_ctrl.sv
// UART-to-register-file command initiator: parses AA/BB frames, strobes the register file, returns read bytes to TX.
// Optional read-wait timeout is compiled in with `define RD_TIMEOUT_EN.
module regfile_cmd_ctrl #(
   parameter int                    data_width    = 8,
   parameter int                    address_width = 4,
   parameter logic [data_width-1:0] CMD_WR        = 8'hAA,
   parameter logic [data_width-1:0] CMD_RD        = 8'hBB,
   parameter int                    TIMEOUT       = 15
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic [data_width-1:0]    RX_P_DATA,
   input  logic                     RX_D_VLD,
   input  logic [data_width-1:0]    RdData,
   input  logic                     RdData_Valid,
   input  logic                     TX_BUSY,
   output logic                     WrEn,
   output logic                     RdEn,
   output logic [address_width-1:0] Address,
   output logic [data_width-1:0]    WrData,
   output logic [data_width-1:0]    TX_P_DATA,
   output logic                     TX_D_VLD,
   output logic                     FRAME_ERR
);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      TX_SEND
   } state_t;

   state_t                   state, state_nxt;
   logic [data_width-1:0]    buffer, buffer_nxt;
   logic                     wr_en_nxt, rd_en_nxt, tx_vld_nxt, frame_err_nxt;
   logic [address_width-1:0] address_nxt;
   logic [data_width-1:0]    wr_data_nxt, tx_data_nxt;

`ifdef RD_TIMEOUT_EN
   localparam int                    cnt_w        = $clog2(TIMEOUT + 1);
   localparam logic [data_width-1:0] TIMEOUT_BYTE = data_width'(8'hEE);

   logic [cnt_w-1:0] count, count_nxt;
`endif

   always_comb begin
      state_nxt     = state;
      buffer_nxt    = buffer;
      wr_en_nxt     = 1'b0;
      rd_en_nxt     = 1'b0;
      tx_vld_nxt    = 1'b0;
      frame_err_nxt = 1'b0;
      address_nxt   = Address;
      wr_data_nxt   = WrData;
      tx_data_nxt   = TX_P_DATA;
`ifdef RD_TIMEOUT_EN
      count_nxt     = count;
`endif

      case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_WR) begin
                  state_nxt = WR_ADDR;
               end else if (RX_P_DATA == CMD_RD) begin
                  state_nxt = RD_ADDR;
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end
         end

         WR_ADDR: begin
            if (RX_D_VLD) begin
               address_nxt = RX_P_DATA[address_width-1:0];
               state_nxt   = WR_DATA;
            end
         end

         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_data_nxt = RX_P_DATA;
               wr_en_nxt   = 1'b1;
               state_nxt   = IDLE;
            end
         end

         RD_ADDR: begin
            if (RX_D_VLD) begin
               address_nxt = RX_P_DATA[address_width-1:0];
               rd_en_nxt   = 1'b1;
               state_nxt   = RD_WAIT;
`ifdef RD_TIMEOUT_EN
               count_nxt   = '0;
`endif
            end
         end

         RD_WAIT: begin
            if (RdData_Valid) begin
               buffer_nxt = RdData;
               state_nxt  = TX_SEND;
            end
`ifdef RD_TIMEOUT_EN
            // count holds the number of RD_WAIT edges already spent; this edge is the TIMEOUT-th
            else if (count == cnt_w'(TIMEOUT - 1)) begin
               buffer_nxt    = TIMEOUT_BYTE;
               frame_err_nxt = 1'b1;
               state_nxt     = TX_SEND;
            end else begin
               count_nxt = count + 1'b1;
            end
`endif
         end

         TX_SEND: begin
            if (!TX_BUSY) begin
               tx_data_nxt = buffer;
               tx_vld_nxt  = 1'b1;
               state_nxt   = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         buffer    <= '0;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         FRAME_ERR <= 1'b0;
`ifdef RD_TIMEOUT_EN
         count     <= '0;
`endif
      end else begin
         state     <= state_nxt;
         buffer    <= buffer_nxt;
         WrEn      <= wr_en_nxt;
         RdEn      <= rd_en_nxt;
         Address   <= address_nxt;
         WrData    <= wr_data_nxt;
         TX_P_DATA <= tx_data_nxt;
         TX_D_VLD  <= tx_vld_nxt;
         FRAME_ERR <= frame_err_nxt;
`ifdef RD_TIMEOUT_EN
         count     <= count_nxt;
`endif
      end
   end

endmodule
